dmem_rsp: RTL and testbench
===========================

# dmem_rsp

Data-memory responder for the RISC-V lab cores. It sits on the memory side of the load/store path, owns the data storage array, and serves one request at a time through a valid/ready request channel and a valid/ready response channel. It handles byte and halfword lane placement for stores and extraction with extension for loads, checks alignment, and inserts a programmable number of wait states. Multi-cycle CPU variants use it in place of the combinational data memory.

## Interface
Parameters:
- DMEM_DEPTH, 1024: number of 32-bit words of storage.
- DMEM_ADDR_WIDTH, 10: word-index width; must equal log2(DMEM_DEPTH).
- WAIT_CYCLES, 2: wait states between request acceptance and the array access. Legal range is 0..15.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- reset_b, input, 1: asynchronous reset, active low.
- req_valid, input, 1: a request is present.
- req_ready, output, 1: the responder can accept a request.
- req_write, input, 1: 1 = store, 0 = load.
- req_addr, input, 32: byte address.
- req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned, input, 1: zero-extend the load result. 0 = sign-extend.
- req_wdata, input, 32: store data. Only the low size bytes are significant.
- rsp_valid, output, 1: a response is held.
- rsp_ready, input, 1: the initiator accepts the response.
- rsp_rdata, output, 32: load result. Forced to 0 for stores and for errors.
- rsp_err, output, 1: the request faulted (misaligned or illegal size).

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- req_ready = 1 only in IDLE.
- IDLE:
  - Acceptance occurs on an edge where req_valid && req_ready.
  - On acceptance, the block latches write, addr, size, unsigned and wdata.
  - Next state is WAIT with counter = WAIT_CYCLES-1. If WAIT_CYCLES = 0, next state is ACCESS.
- WAIT: the counter decrements each cycle. At 0 the FSM goes to ACCESS.
- ACCESS: one cycle.
  - Word index = addr[DMEM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DMEM_DEPTH.
  - Store, byte: wdata[7:0] is written to lane addr[1:0].
  - Store, half: wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Store, word: all four lanes are written.
  - Lanes that are not written keep their contents.
  - Load: the addressed lane(s) are extracted, then sign- or zero-extended to 32 bits per unsigned. Word loads ignore unsigned.
  - The result is registered into rsp_rdata and rsp_err. Next state is RESP.
- Faults:
  - Fault = size 11, or half with addr[0] = 1, or word with addr[1:0] != 0.
  - A faulting request performs no array write, returns rsp_rdata = 0 and rsp_err = 1.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable.
  - When rsp_valid && rsp_ready, the FSM goes to IDLE and rsp_valid falls at that edge.
- Array contents are not reset. The simulation initial value is 0.

## Timing
- Reset values: FSM = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
- Reset asserted mid-request:
  - The request is dropped.
  - If reset arrives before the ACCESS edge, no array write occurs.
  - No response is produced.
- Latency: with acceptance at edge k, rsp_valid is high after edge k+WAIT_CYCLES+1.
  - Example: for WAIT_CYCLES = 2, accept at edge 0 and rsp_valid rises after edge 3.
- Back-to-back requests: one request completes every WAIT_CYCLES+3 cycles at best (RESP, then IDLE re-accept).
  - A request held on req_valid during RESP is accepted on the first IDLE cycle.
- rsp_ready stalls are unbounded. Outputs stay stable while RESP is held.
- Request inputs are sampled only at the acceptance edge. Changes afterward have no effect.
- Store data is visible to a load accepted after the store's response handshake.

## Configuration
- DMEM_RSP_ALIGN_CHECK_EN defined:
  - Fault checking is as described above.
- DMEM_RSP_ALIGN_CHECK_EN undefined:
  - No alignment fault occurs. rsp_err is tied to 0.
  - Half accesses force addr[0] = 0, word accesses force addr[1:0] = 00, and the access proceeds.
  - Size 11 is treated as word.

## Test plan
- Word round trip, WAIT_CYCLES = 2: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid rises 3 edges after each acceptance.
- Byte lanes: after the word store, store byte 0x7F to 0x13 -> word 0x7FADBEEF.
  - Load byte 0x12 signed -> 0xFFFFFFAD.
  - Load byte 0x12 unsigned -> 0x000000AD.
- Half: store half 0x8001 to 0x20, then load half 0x20 signed -> 0xFFFF8001.
  - Same load unsigned -> 0x00008001.
- Misaligned, ALIGN_CHECK_EN: store word 0x11111111 to 0x22 -> err 1, rdata 0, and a load word from 0x20 is unchanged.
  - Without the macro: err 0, and the word at 0x20 becomes 0x11111111.
- Backpressure: hold rsp_ready = 0 for 10 cycles -> rsp_valid and rsp_rdata stay constant and req_ready = 0. Release -> next request accepted one cycle later.
- Reset mid-request: accept a store to 0x30, pulse reset_b low during WAIT -> rsp_valid stays 0 and a subsequent load from 0x30 returns the previous value. Also wrap check: address 0x1000 aliases 0x0.

Source files
------------

// File: rtl/dmem_rsp.sv
// Data-memory responder: one request at a time over valid/ready channels.
// It adds WAIT_CYCLES wait states, places store lanes and extends load lanes.
// Optional DMEM_RSP_ALIGN_CHECK_EN reports misaligned or illegal accesses as faults.
module dmem_rsp #(
   parameter int DMEM_DEPTH      = 1024,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int WAIT_CYCLES     = 2
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [3:0]                 r_cnt;
   logic [3:0]                 w_cnt_nxt;

   logic                       r_write;
   logic [DMEM_ADDR_WIDTH+1:0] r_addr;
   logic [1:0]                 r_size;
   logic                       r_unsigned;
   logic [31:0]                r_wdata;
   logic [31:0]                r_rdata;
   logic                       r_err;

   logic [31:0]                r_mem [DMEM_DEPTH];

   logic [DMEM_ADDR_WIDTH-1:0] w_idx;
   logic [1:0]                 w_lane;
   logic [1:0]                 w_size;
   logic                       w_fault;
   logic [31:0]                w_mem_word;
   logic [31:0]                w_mask;
   logic [31:0]                w_wpat;
   logic [31:0]                w_load;
   logic                       w_unused_addr;

   function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   res = {{24{~uns & sh[7]}}, sh[7:0]};
         2'b01:   res = {{16{~uns & sh[15]}}, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] f_lane_mask(input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] m;
      case (size)
         2'b00:   m = 32'h0000_00FF << {lane, 3'b000};
         2'b01:   m = 32'h0000_FFFF << {lane, 3'b000};
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] f_store_pat(input logic [31:0] wdata, input logic [1:0] size);
      logic [31:0] p;
      case (size)
         2'b00:   p = {4{wdata[7:0]}};
         2'b01:   p = {2{wdata[15:0]}};
         default: p = wdata;
      endcase
      return p;
   endfunction

   assign w_unused_addr = ^req_addr[31:DMEM_ADDR_WIDTH+2];

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

`ifdef DMEM_RSP_ALIGN_CHECK_EN
   assign w_size  = r_size;
   assign w_lane  = r_addr[1:0];
   assign w_fault = (r_size == 2'b11) ||
                    ((r_size == 2'b01) && r_addr[0]) ||
                    ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
   // Without checking, low address bits are masked to the access size; size 11 acts as word.
   assign w_size  = (r_size == 2'b11) ? 2'b10 : r_size;
   assign w_lane  = (w_size == 2'b00) ? r_addr[1:0] :
                    (w_size == 2'b01) ? {r_addr[1], 1'b0} : 2'b00;
   assign w_fault = 1'b0;
`endif

   assign w_idx      = r_addr[DMEM_ADDR_WIDTH+1:2];
   assign w_mem_word = r_mem[w_idx];
   assign w_mask     = f_lane_mask(w_lane, w_size);
   assign w_wpat     = f_store_pat(r_wdata, w_size);
   assign w_load     = f_load_ext(w_mem_word, w_lane, w_size, r_unsigned);

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = ACCESS;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = ACCESS;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         ACCESS:  w_state_nxt = RESP;
         RESP:    if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request fields are captured only at acceptance; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         r_write    <= req_write;
         r_addr     <= req_addr[DMEM_ADDR_WIDTH+1:0];
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_wdata    <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == ACCESS) && r_write && !w_fault)
         r_mem[w_idx] <= (w_mem_word & ~w_mask) | (w_wpat & w_mask);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (r_state == ACCESS) begin
         r_rdata <= (r_write || w_fault) ? 32'd0 : w_load;
         r_err   <= w_fault;
      end
   end

endmodule

// File: tb/tb_dmem_rsp.sv
// Scoreboard bench for dmem_rsp: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_dmem_rsp;

   localparam int WAITC = 2;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_rsp #(
      .DMEM_DEPTH(1024),
      .DMEM_ADDR_WIDTH(10),
      .WAIT_CYCLES(WAITC)
   ) dut (
      .clk(clk),
      .reset_b(reset_b),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one pop per response handshake.
   always @(negedge clk) begin
      if (reset_b && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rdata %h err %b, expected no response", rsp_rdata, rsp_err);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
         end
      end
   end

   task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d);
      req_valid    = 1'b1;
      req_write    = w;
      req_addr     = a;
      req_size     = s;
      req_unsigned = u;
      req_wdata    = d;
   endtask

   task automatic accept(input logic push, input logic [31:0] er, input logic ee);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready %b, expected 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      if (push) sb.push_back(exp_t'{rdata: er, err: ee});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = ~req_wdata;
      req_size  = ~req_size;
      req_write = ~req_write;
   endtask

   task automatic finish_rsp(input string name);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(WAITC + 1));
      n = 0;
      while (rsp_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (rsp_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: got rsp_valid %b, expected 0", name, rsp_valid);
      end
   endtask

   task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] d, input logic [31:0] er, input logic ee);
      drive(w, a, s, u, d);
      accept(1'b1, er, ee);
      finish_rsp(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] w20;
      reset_b      = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = 32'd0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_wdata    = 32'd0;
      rsp_ready    = 1'b1;
      #12;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk);
      #1;
      reset_b = 1'b1;

      // Word round trip and byte lanes
      txn("st_w10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0);
      txn("ld_w10", 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
      txn("st_b13", 1'b1, 32'h13, 2'b00, 1'b0, 32'hAAAAAA7F, 32'd0, 1'b0);
      txn("ld_w10b", 1'b0, 32'h10, 2'b10, 1'b1, 32'd0, 32'h7FADBEEF, 1'b0);
      txn("ld_b12s", 1'b0, 32'h12, 2'b00, 1'b0, 32'd0, 32'hFFFFFFAD, 1'b0);
      txn("ld_b12u", 1'b0, 32'h12, 2'b00, 1'b1, 32'd0, 32'h000000AD, 1'b0);
      txn("ld_b13s", 1'b0, 32'h13, 2'b00, 1'b0, 32'd0, 32'h0000007F, 1'b0);

      // Halfword
      txn("st_w20z", 1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 32'd0, 1'b0);
      txn("st_h20", 1'b1, 32'h20, 2'b01, 1'b0, 32'h12348001, 32'd0, 1'b0);
      txn("ld_h20s", 1'b0, 32'h20, 2'b01, 1'b0, 32'd0, 32'hFFFF8001, 1'b0);
      txn("ld_h20u", 1'b0, 32'h20, 2'b01, 1'b1, 32'd0, 32'h00008001, 1'b0);

      // Misaligned and illegal size
`ifdef DMEM_RSP_ALIGN_CHECK_EN
      txn("st_w22", 1'b1, 32'h22, 2'b10, 1'b0, 32'h11111111, 32'd0, 1'b1);
      w20 = 32'h00008001;
      txn("ld_w20", 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, w20, 1'b0);
      txn("ld_h21", 1'b0, 32'h21, 2'b01, 1'b0, 32'd0, 32'd0, 1'b1);
      txn("ld_s3", 1'b0, 32'h20, 2'b11, 1'b0, 32'd0, 32'd0, 1'b1);
`else
      txn("st_w22", 1'b1, 32'h22, 2'b10, 1'b0, 32'h11111111, 32'd0, 1'b0);
      w20 = 32'h11111111;
      txn("ld_w20", 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, w20, 1'b0);
      txn("ld_h21", 1'b0, 32'h21, 2'b01, 1'b0, 32'd0, 32'h00001111, 1'b0);
      txn("ld_s3", 1'b0, 32'h20, 2'b11, 1'b0, 32'd0, w20, 1'b0);
`endif

      // Backpressure with a request held during RESP
      rsp_ready = 1'b0;
      drive(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
      accept(1'b1, 32'h7FADBEEF, 1'b0);
      repeat (WAITC + 1) begin
         @(posedge clk);
         #1;
      end
      chk("bp_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
      drive(1'b0, 32'h12, 2'b00, 1'b1, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h7FADBEEF);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_rel_idle", {31'd0, req_ready}, 32'd1);
      chk("bp_rel_valid", {31'd0, rsp_valid}, 32'd0);
      sb.push_back(exp_t'{rdata: 32'h000000AD, err: 1'b0});
      @(posedge clk);
      #1;
      chk("bp_reaccept", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      finish_rsp("bp_next");

      // Reset during WAIT drops the request
      txn("st_w30", 1'b1, 32'h30, 2'b10, 1'b0, 32'h5A5A5A5A, 32'd0, 1'b0);
      drive(1'b1, 32'h30, 2'b10, 1'b0, 32'hCAFEF00D);
      accept(1'b0, 32'd0, 1'b0);
      reset_b = 1'b0;
      #2;
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      reset_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      txn("ld_w30", 1'b0, 32'h30, 2'b10, 1'b0, 32'd0, 32'h5A5A5A5A, 1'b0);

      // Address wrap
      txn("st_w1000", 1'b1, 32'h1000, 2'b10, 1'b0, 32'h0BADCAFE, 32'd0, 1'b0);
      txn("ld_w0", 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 32'h0BADCAFE, 1'b0);

      repeat (3) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
